// File: rtl/riscv_mem_pkg.sv
// Load/store encodings and helpers shared by the MEM stage: byte-enable
// generation and misalignment detection.
package riscv_mem_pkg;

    localparam logic [2:0] LD_LB   = 3'b000;
    localparam logic [2:0] LD_LH   = 3'b001;
    localparam logic [2:0] LD_LW   = 3'b010;
    localparam logic [2:0] LD_LBU  = 3'b100;
    localparam logic [2:0] LD_LHU  = 3'b101;
    localparam logic [2:0] LD_NONE = 3'b111;

    localparam logic [1:0] ST_SB   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SW   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    function automatic logic [3:0] store_byte_en(input logic [1:0] st_type,
                                                 input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (st_type)
            ST_SB:   be = 4'b0001 << addr_lo;
            ST_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            ST_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic load_misaligned(input logic [2:0] ld_type,
                                             input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (ld_type)
            LD_LH, LD_LHU: mis = addr_lo[0];
            LD_LW:         mis = (addr_lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic store_misaligned(input logic [1:0] st_type,
                                              input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (st_type)
            ST_SH:   mis = addr_lo[0];
            ST_SW:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic access_misaligned(input logic       rd_en,
                                               input logic       wr_en,
                                               input logic [2:0] ld_type,
                                               input logic [1:0] st_type,
                                               input logic [1:0] addr_lo);
        return (rd_en && load_misaligned(ld_type, addr_lo)) ||
               (wr_en && store_misaligned(st_type, addr_lo));
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port data RAM, one byte-wide array per lane so each lane has its own
// write enable; registered read, no reset so it maps onto block RAM.
module dmem_bram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH_WORDS];
            logic [7:0] r_rd_byte;

            // Read returns the pre-write contents on a same-address write.
            always_ff @(posedge clk) begin
                if (i_we[gi]) begin
                    r_lane[i_addr] <= i_wdata[gi*8 +: 8];
                end
                r_rd_byte <= r_lane[i_addr];
            end

            assign o_rdata[gi*8 +: 8] = r_rd_byte;
        end
    endgenerate

endmodule

// File: rtl/mem_stage_wb_pipe.sv
// MEM stage and MEM/WB register: formats stores into the data RAM, registers
// the write-back operands and aligns/extends load data in the WB cycle.
module mem_stage_wb_pipe
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic [4:0]  rd_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_load_type_mem,
    input  logic [1:0]  mem_store_type_mem,
    input  logic        wb_reg_file_mem,
    input  logic        memtoreg_mem,
    output logic [31:0] alu_result_wb,
    output logic [31:0] load_data_wb,
    output logic [4:0]  rd_wb,
    output logic        wb_reg_file_wb,
    output logic        memtoreg_wb,
    output logic        misaligned_wb
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [1:0]       w_addr_lo;
    logic [IDX_W-1:0] w_word_idx;
    logic             w_ld_mis;
    logic             w_st_mis;
    logic             w_misaligned;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_store_data;
    logic [31:0]      w_ram_rdata;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load_data;

    logic [31:0]      r_alu_result;
    logic [4:0]       r_rd;
    logic             r_wb_reg_file;
    logic             r_memtoreg;
    logic             r_misaligned;
    logic [2:0]       r_ld_type;
    logic [1:0]       r_addr_lo;

    assign w_addr_lo    = alu_result_mem[1:0];
    assign w_word_idx   = alu_result_mem[IDX_W+1:2];
    assign w_ld_mis     = mem_read_mem && load_misaligned(mem_load_type_mem, w_addr_lo);
    assign w_st_mis     = mem_write_mem && store_misaligned(mem_store_type_mem, w_addr_lo);
    assign w_misaligned = access_misaligned(mem_read_mem, mem_write_mem,
                                            mem_load_type_mem, mem_store_type_mem,
                                            w_addr_lo);

    // Reset and misalignment both suppress the write entirely.
    assign w_byte_en = (mem_write_mem && !w_st_mis && !rst)
                     ? store_byte_en(mem_store_type_mem, w_addr_lo) : 4'b0000;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_st_lane
            assign w_store_data[gi*8 +: 8] =
                (mem_store_type_mem == ST_SB) ? rs2_data_mem[7:0] :
                (mem_store_type_mem == ST_SH) ? rs2_data_mem[(gi%2)*8 +: 8] :
                                                rs2_data_mem[gi*8 +: 8];
        end
    endgenerate

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_byte_en),
        .i_addr  (w_word_idx),
        .i_wdata (w_store_data),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_result  <= 32'd0;
            r_rd          <= 5'd0;
            r_wb_reg_file <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_misaligned  <= 1'b0;
            r_ld_type     <= LD_NONE;
            r_addr_lo     <= 2'b00;
        end else begin
            r_alu_result  <= alu_result_mem;
            r_rd          <= rd_mem;
            r_wb_reg_file <= wb_reg_file_mem && !w_ld_mis;
            r_memtoreg    <= memtoreg_mem;
            r_misaligned  <= w_misaligned;
            // A load that is absent, misaligned or paired with a store yields zero.
            r_ld_type     <= (mem_read_mem && !mem_write_mem && !w_ld_mis)
                           ? mem_load_type_mem : LD_NONE;
            r_addr_lo     <= w_addr_lo;
        end
    end

    assign w_shifted = w_ram_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        w_load_data = 32'd0;
        case (r_ld_type)
            LD_LB:   w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LD_LH:   w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LD_LW:   w_load_data = w_ram_rdata;
            LD_LBU:  w_load_data = {24'd0, w_shifted[7:0]};
            LD_LHU:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = 32'd0;
        endcase
    end

    assign alu_result_wb  = r_alu_result;
    assign load_data_wb   = w_load_data;
    assign rd_wb          = r_rd;
    assign wb_reg_file_wb = r_wb_reg_file;
    assign memtoreg_wb    = r_memtoreg;
    assign misaligned_wb  = r_misaligned;

endmodule

// File: tb/tb_mem_stage_wb_pipe.sv
// Directed and randomized bench for mem_stage_wb_pipe against a byte-level
// memory model.
module tb_mem_stage_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_mem;
    logic [31:0] rs2_data_mem;
    logic [4:0]  rd_mem;
    logic        mem_write_mem;
    logic        mem_read_mem;
    logic [2:0]  mem_load_type_mem;
    logic [1:0]  mem_store_type_mem;
    logic        wb_reg_file_mem;
    logic        memtoreg_mem;
    logic [31:0] alu_result_wb;
    logic [31:0] load_data_wb;
    logic [4:0]  rd_wb;
    logic        wb_reg_file_wb;
    logic        memtoreg_wb;
    logic        misaligned_wb;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model_mem [1024];

    mem_stage_wb_pipe #(.DEPTH_WORDS(1024)) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_result_mem     (alu_result_mem),
        .rs2_data_mem       (rs2_data_mem),
        .rd_mem             (rd_mem),
        .mem_write_mem      (mem_write_mem),
        .mem_read_mem       (mem_read_mem),
        .mem_load_type_mem  (mem_load_type_mem),
        .mem_store_type_mem (mem_store_type_mem),
        .wb_reg_file_mem    (wb_reg_file_mem),
        .memtoreg_mem       (memtoreg_mem),
        .alu_result_wb      (alu_result_wb),
        .load_data_wb       (load_data_wb),
        .rd_wb              (rd_wb),
        .wb_reg_file_wb     (wb_reg_file_wb),
        .memtoreg_wb        (memtoreg_wb),
        .misaligned_wb      (misaligned_wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ld_size(input logic [2:0] lt);
        case (lt)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic int st_size(input logic [1:0] st);
        case (st)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // One instruction through the stage; checks the WB outputs one edge later.
    task automatic do_op(input string tag, input logic rst_v, input logic r_en, input logic w_en,
                         input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] addr, input logic [31:0] data);
        int          lsz, ssz, off, widx;
        logic        ld_mis, st_mis;
        logic [31:0] w, v, e_ld, word;
        logic [4:0]  rdv;
        logic        wbe, m2r;
        rdv  = 5'($urandom);
        wbe  = 1'($urandom);
        m2r  = r_en ? 1'b1 : 1'($urandom);
        lsz  = ld_size(lt);
        ssz  = st_size(st);
        off  = int'(addr % 4);
        widx = int'((addr / 4) % 1024);
        ld_mis = r_en && lsz > 1 && (off % lsz) != 0;
        st_mis = w_en && ssz > 1 && (off % ssz) != 0;
        e_ld = 32'd0;
        if (r_en && !w_en && !ld_mis && lsz > 0) begin
            w = model_mem[widx] >> (8 * off);
            if (lsz == 1) begin
                v = w & 32'h0000_00FF;
                if (lt == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (lsz == 2) begin
                v = w & 32'h0000_FFFF;
                if (lt == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            e_ld = v;
        end

        rst = rst_v;
        alu_result_mem = addr;
        rs2_data_mem = data;
        rd_mem = rdv;
        mem_read_mem = r_en;
        mem_write_mem = w_en;
        mem_load_type_mem = lt;
        mem_store_type_mem = st;
        wb_reg_file_mem = wbe;
        memtoreg_mem = m2r;
        @(posedge clk);
        #1;

        if (rst_v) begin
            check({tag, ".alu"}, alu_result_wb, 32'd0);
            check({tag, ".ld"},  load_data_wb, 32'd0);
            check({tag, ".rd"},  {27'd0, rd_wb}, 32'd0);
            check({tag, ".wbe"}, {31'd0, wb_reg_file_wb}, 32'd0);
            check({tag, ".m2r"}, {31'd0, memtoreg_wb}, 32'd0);
            check({tag, ".mis"}, {31'd0, misaligned_wb}, 32'd0);
        end else begin
            check({tag, ".alu"}, alu_result_wb, addr);
            check({tag, ".ld"},  load_data_wb, e_ld);
            check({tag, ".rd"},  {27'd0, rd_wb}, {27'd0, rdv});
            check({tag, ".wbe"}, {31'd0, wb_reg_file_wb}, {31'd0, wbe && !ld_mis});
            check({tag, ".m2r"}, {31'd0, memtoreg_wb}, {31'd0, m2r});
            check({tag, ".mis"}, {31'd0, misaligned_wb}, {31'd0, ld_mis || st_mis});
            if (w_en && ssz > 0 && !st_mis) begin
                word = model_mem[widx];
                for (int b = 0; b < ssz; b++) begin
                    word[8*(off+b) +: 8] = data[8*b +: 8];
                end
                model_mem[widx] = word;
            end
        end
        $display("[TB] %s rst=%0b rd=%0b wr=%0b lt=%0d st=%0d a=%h d=%h ld=%h mis=%0b",
                 tag, rst_v, r_en, w_en, lt, st, addr, data, load_data_wb, misaligned_wb);
    endtask

    logic [2:0] lt_tab [6];

    initial begin
        logic [31:0] a, d;
        int kind;
        lt_tab[0] = 3'b000; lt_tab[1] = 3'b001; lt_tab[2] = 3'b010;
        lt_tab[3] = 3'b100; lt_tab[4] = 3'b101; lt_tab[5] = 3'b111;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;

        do_op("reset0", 1'b1, 1'b0, 1'b0, 3'b111, 2'b11, 32'h0, 32'h0);
        do_op("reset1", 1'b1, 1'b0, 1'b0, 3'b111, 2'b11, 32'h0, 32'h0);

        // Give the working region known contents.
        for (int i = 0; i < 32; i++) begin
            do_op("init", 1'b0, 1'b0, 1'b1, 3'b111, 2'b10, 32'(i * 4), $urandom);
        end

        do_op("sw_dead", 1'b0, 1'b0, 1'b1, 3'b111, 2'b10, 32'h10, 32'hDEADBEEF);
        do_op("lw_dead", 1'b0, 1'b1, 1'b0, 3'b010, 2'b11, 32'h10, 32'h0);
        check("lw_dead.const", load_data_wb, 32'hDEADBEEF);
        check("lw_dead.m2r1", {31'd0, memtoreg_wb}, 32'd1);

        do_op("sb80", 1'b0, 1'b0, 1'b1, 3'b111, 2'b00, 32'h21, 32'h1234_5680);
        do_op("lb21", 1'b0, 1'b1, 1'b0, 3'b000, 2'b11, 32'h21, 32'h0);
        check("lb21.const", load_data_wb, 32'hFFFF_FF80);
        do_op("lbu21", 1'b0, 1'b1, 1'b0, 3'b100, 2'b11, 32'h21, 32'h0);
        check("lbu21.const", load_data_wb, 32'h0000_0080);
        do_op("lw20", 1'b0, 1'b1, 1'b0, 3'b010, 2'b11, 32'h20, 32'h0);

        do_op("sh8001", 1'b0, 1'b0, 1'b1, 3'b111, 2'b01, 32'h32, 32'h5555_8001);
        do_op("lh32", 1'b0, 1'b1, 1'b0, 3'b001, 2'b11, 32'h32, 32'h0);
        check("lh32.const", load_data_wb, 32'hFFFF_8001);
        do_op("lhu32", 1'b0, 1'b1, 1'b0, 3'b101, 2'b11, 32'h32, 32'h0);
        check("lhu32.const", load_data_wb, 32'h0000_8001);
        do_op("lw30", 1'b0, 1'b1, 1'b0, 3'b010, 2'b11, 32'h30, 32'h0);
        check("lw30.upper", load_data_wb >> 16, 32'h0000_8001);

        do_op("lw13mis", 1'b0, 1'b1, 1'b0, 3'b010, 2'b11, 32'h13, 32'h0);
        check("lw13.mis1", {31'd0, misaligned_wb}, 32'd1);
        do_op("sw12mis", 1'b0, 1'b0, 1'b1, 3'b111, 2'b10, 32'h12, 32'hCAFE_F00D);
        do_op("lw10old", 1'b0, 1'b1, 1'b0, 3'b010, 2'b11, 32'h10, 32'h0);
        check("lw10old.const", load_data_wb, 32'hDEADBEEF);

        do_op("sw_wrap", 1'b0, 1'b0, 1'b1, 3'b111, 2'b10, 32'h1000, 32'h1234_5678);
        do_op("lw_wrap", 1'b0, 1'b1, 1'b0, 3'b010, 2'b11, 32'h0, 32'h0);
        check("lw_wrap.const", load_data_wb, 32'h1234_5678);

        do_op("sw_rst", 1'b1, 1'b0, 1'b1, 3'b111, 2'b10, 32'h40, 32'hAAAA_AAAA);
        do_op("lw40", 1'b0, 1'b1, 1'b0, 3'b010, 2'b11, 32'h40, 32'h0);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
              | 32'($urandom_range(0, 3));
            d = $urandom;
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 39) == 0) begin
                do_op("rnd_rst", 1'b1, 1'b0, 1'b1, 3'b111, 2'($urandom), a, d);
            end else if (kind == 0) begin
                do_op("rnd_ld", 1'b0, 1'b1, 1'b0, lt_tab[$urandom_range(0, 5)], 2'b11, a, d);
            end else if (kind == 1) begin
                do_op("rnd_st", 1'b0, 1'b0, 1'b1, 3'b111, 2'($urandom), a, d);
            end else begin
                do_op("rnd_nop", 1'b0, 1'b0, 1'b0, lt_tab[$urandom_range(0, 5)], 2'($urandom), a, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
